// File: rtl/ahb_lite_cmd_master.sv
`timescale 1ns/1ps
// Single-channel AHB-Lite initiator: valid/ready commands in, pipelined NONSEQ singles out,
// one response per command. Handles wait states and the two-cycle ERROR cancel/reissue.
module ahb_lite_cmd_master (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [31:0] HRDATA
);
    logic        r_a_vld, r_a_hold, r_a_write;
    logic [31:0] r_a_addr, r_a_wdata;
    logic [1:0]  r_a_size;
    logic        r_d_vld, r_d_write;
    logic [31:0] r_d_wdata;
    logic        r_rsp_valid, r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic [1:0]  w_size;
    logic [31:0] w_addr;

    // Size 3 is clamped to word; address low bits are aligned to the clamped size.
    always_comb begin
        w_size = (cmd_size == 2'd3) ? 2'd2 : cmd_size;
        w_addr = cmd_addr;
        if (w_size == 2'd1)
            w_addr[0] = 1'b0;
        else if (w_size == 2'd2)
            w_addr[1:0] = 2'b00;
    end

    assign cmd_ready = HREADY & ~r_a_hold;
    assign busy      = r_a_vld | r_d_vld;
    assign HTRANS    = (r_a_vld & ~r_a_hold) ? 2'b10 : 2'b00;
    assign HADDR     = r_a_addr;
    assign HWRITE    = r_a_write;
    assign HSIZE     = {1'b0, r_a_size};
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HWDATA    = r_d_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_a_vld     <= 1'b0;
            r_a_hold    <= 1'b0;
            r_a_write   <= 1'b0;
            r_a_addr    <= '0;
            r_a_size    <= '0;
            r_a_wdata   <= '0;
            r_d_vld     <= 1'b0;
            r_d_write   <= 1'b0;
            r_d_wdata   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (r_d_vld && HREADY) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= HRESP;
                if (!r_d_write)
                    r_rsp_rdata <= HRDATA;
            end

            if (HREADY) begin
                if (r_a_hold) begin
                    // Second ERROR cycle: the bus saw IDLE, so no data phase follows.
                    r_d_vld  <= 1'b0;
                    r_a_hold <= 1'b0;
                end else begin
                    r_d_vld   <= r_a_vld;
                    r_d_write <= r_a_write;
                    r_d_wdata <= r_a_wdata;
                    if (cmd_valid) begin
                        r_a_vld   <= 1'b1;
                        r_a_write <= cmd_write;
                        r_a_addr  <= w_addr;
                        r_a_size  <= w_size;
                        r_a_wdata <= cmd_wdata;
                    end else begin
                        r_a_vld <= 1'b0;
                    end
                end
            end else if (r_d_vld && HRESP && r_a_vld) begin
                r_a_hold <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
`timescale 1ns/1ps
// Directed bench for ahb_lite_cmd_master: stimulus pushes expected responses
// (with expected cycle) into a queue, a negedge monitor pops and compares them.
module tb_ahb_lite_cmd_master;
    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [1:0]  cmd_size;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    ahb_lite_cmd_master dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;

    int unsigned cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic        err;
        logic        chk_rd;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int unsigned c, input logic e, input logic cr, input logic [31:0] rd);
        exp_t x;
        x.cyc = c; x.err = e; x.chk_rd = cr; x.rdata = rd;
        sb.push_back(x);
    endtask

    task automatic step();
        @(negedge HCLK);
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
    endtask

    always @(negedge HCLK) begin : monitor
        exp_t e;
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected none (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk("rsp_cycle", cyc, e.cyc);
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                if (e.chk_rd) chk("rsp_rdata", rsp_rdata, e.rdata);
            end
        end
    end

    initial begin
        HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_size = '0; cmd_wdata = '0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        repeat (2) step();
        chk("rst_htrans", {30'b0, HTRANS}, 32'h0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwrite", {31'b0, HWRITE}, 32'h0);
        chk("rst_hsize", {29'b0, HSIZE}, 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
        chk("hburst", {29'b0, HBURST}, 32'h0);
        chk("hprot", {28'b0, HPROT}, 32'h3);
        HRESETn = 1'b1;
        step();

        // Zero-wait word write
        issue(1'b1, 32'h4000_0000, 2'd2, 32'h0000_1234);
        #1 chk("t1_ready", {31'b0, cmd_ready}, 32'h1);
        push(cyc + 3, 1'b0, 1'b0, '0);
        step();
        cmd_valid = 1'b0;
        chk("t1_htrans", {30'b0, HTRANS}, 32'h2);
        chk("t1_haddr", HADDR, 32'h4000_0000);
        chk("t1_hwrite", {31'b0, HWRITE}, 32'h1);
        chk("t1_hsize", {29'b0, HSIZE}, 32'h2);
        step();
        chk("t1_hwdata", HWDATA, 32'h0000_1234);
        chk("t1_idle", {30'b0, HTRANS}, 32'h0);
        repeat (3) step();

        // Read with two wait states in the data phase
        issue(1'b0, 32'h4000_0000, 2'd2, '0);
        push(cyc + 5, 1'b0, 1'b1, 32'h0000_0015);
        step();
        cmd_valid = 1'b0;
        chk("t2_htrans", {30'b0, HTRANS}, 32'h2);
        chk("t2_hwrite", {31'b0, HWRITE}, 32'h0);
        step();
        HREADY = 1'b0;
        chk("t2_busy", {31'b0, busy}, 32'h1);
        step();
        step();
        HREADY = 1'b1; HRDATA = 32'h0000_0015;
        step();
        HRDATA = '0;
        repeat (3) step();

        // Four back-to-back writes
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 32'(i * 4), 2'd2, 32'(32'hA0 + i));
            #1 chk("t3_ready", {31'b0, cmd_ready}, 32'h1);
            if (i > 0) begin
                chk("t3_htrans", {30'b0, HTRANS}, 32'h2);
                chk("t3_haddr", HADDR, 32'((i - 1) * 4));
            end
            if (i > 1) chk("t3_hwdata", HWDATA, 32'(32'hA0 + i - 2));
            push(cyc + 3, 1'b0, 1'b0, '0);
            step();
        end
        cmd_valid = 1'b0;
        chk("t3_htrans_last", {30'b0, HTRANS}, 32'h2);
        chk("t3_haddr_last", HADDR, 32'hC);
        repeat (4) step();

        // Read 0x10 errors while write 0x14 is in its address phase
        issue(1'b0, 32'h10, 2'd2, '0);
        push(cyc + 4, 1'b1, 1'b0, '0);
        push(cyc + 6, 1'b0, 1'b0, '0);
        step();
        issue(1'b1, 32'h14, 2'd2, 32'h0000_ABCD);
        chk("t4_rd_haddr", HADDR, 32'h10);
        step();
        cmd_valid = 1'b0;
        chk("t4_wr_htrans", {30'b0, HTRANS}, 32'h2);
        chk("t4_wr_haddr", HADDR, 32'h14);
        HREADY = 1'b0; HRESP = 1'b1;
        step();
        HREADY = 1'b1;
        #1 chk("t4_cancel_htrans", {30'b0, HTRANS}, 32'h0);
        chk("t4_cancel_ready", {31'b0, cmd_ready}, 32'h0);
        chk("t4_cancel_haddr", HADDR, 32'h14);
        step();
        HRESP = 1'b0;
        chk("t4_reissue_htrans", {30'b0, HTRANS}, 32'h2);
        chk("t4_reissue_haddr", HADDR, 32'h14);
        chk("t4_reissue_hwrite", {31'b0, HWRITE}, 32'h1);
        step();
        chk("t4_hwdata", HWDATA, 32'h0000_ABCD);
        repeat (3) step();

        // Alignment and size clamping
        issue(1'b1, 32'h2003, 2'd1, 32'h1);
        push(cyc + 3, 1'b0, 1'b0, '0);
        step();
        issue(1'b1, 32'h3007, 2'd3, 32'h2);
        push(cyc + 3, 1'b0, 1'b0, '0);
        chk("t5_hw_haddr", HADDR, 32'h2002);
        chk("t5_hw_hsize", {29'b0, HSIZE}, 32'h1);
        step();
        issue(1'b1, 32'h5003, 2'd0, 32'h3);
        push(cyc + 3, 1'b0, 1'b0, '0);
        chk("t5_clamp_haddr", HADDR, 32'h3004);
        chk("t5_clamp_hsize", {29'b0, HSIZE}, 32'h2);
        step();
        cmd_valid = 1'b0;
        chk("t5_byte_haddr", HADDR, 32'h5003);
        chk("t5_byte_hsize", {29'b0, HSIZE}, 32'h0);
        repeat (4) step();

        // Reset during a wait-stated read with a second read pipelined
        issue(1'b0, 32'h40, 2'd2, '0);
        step();
        issue(1'b0, 32'h44, 2'd2, '0);
        step();
        cmd_valid = 1'b0;
        HREADY = 1'b0;
        chk("t6_pre_htrans", {30'b0, HTRANS}, 32'h2);
        chk("t6_pre_busy", {31'b0, busy}, 32'h1);
        #2 HRESETn = 1'b0;
        #1;
        chk("t6_htrans", {30'b0, HTRANS}, 32'h0);
        chk("t6_busy", {31'b0, busy}, 32'h0);
        chk("t6_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("t6_haddr", HADDR, 32'h0);
        step();
        step();
        HRESETn = 1'b1;
        HREADY = 1'b1;
        repeat (6) step();

        chk("sb_empty", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
